fns_enc_seq: RTL and testbench

- Multi-cycle greedy Fibonacci-numeral-system (FNS) encoder for one 9-bit CAC segment.
- Sits directly upstream of the 9-bit FNS segment decoder. Its codeword, en_flag and weights feed that decoder unchanged, so decoding the codeword returns the original data.
- Processes one codeword bit per cycle, MSB first.
- Uses valid/ready handshakes on both sides.

---
 rtl/fns_enc_seq.sv | 113 +++++++++++
 tb/tb_fns_enc_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fns_enc_seq.sv
// Sequential greedy Fibonacci-numeral-system encoder for one 9-bit segment.
// Walks the codeword MSB first, one bit per cycle: a bit is set when it is
// enabled and its weight still fits in the remaining residue. A residue left
// over after bit 0 flags the word as not representable with these weights.
module fns_enc_seq #(
    parameter int DATA_W = 7,
    parameter int WGT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [8:0]        en_flag,
    input  logic [WGT_W-1:0]  w03,
    input  logic [WGT_W-1:0]  w04,
    input  logic [WGT_W-1:0]  w05,
    input  logic [WGT_W-1:0]  w06,
    input  logic [WGT_W-1:0]  w07,
    input  logic [WGT_W-1:0]  w08,
    input  logic [WGT_W-1:0]  w09,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        code_out,
    output logic [8:0]        en_out,
    output logic              err
);

    // One spare bit over the wider operand so the compare never truncates.
    localparam int RES_W = ((DATA_W > WGT_W) ? DATA_W : WGT_W) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [RES_W-1:0] residue;
    logic [3:0]       idx;
    logic [WGT_W-1:0] wgt_sel;
    logic [RES_W-1:0] wgt_ext;
    logic             take;
    logic [RES_W-1:0] residue_nxt;

    // Weight of the codeword bit currently being decided; bits 0 and 1 are fixed at 1.
    always_comb begin
        wgt_sel = '0;
        case (idx)
            4'd0, 4'd1: wgt_sel = {{(WGT_W-1){1'b0}}, 1'b1};
            4'd2:       wgt_sel = w03;
            4'd3:       wgt_sel = w04;
            4'd4:       wgt_sel = w05;
            4'd5:       wgt_sel = w06;
            4'd6:       wgt_sel = w07;
            4'd7:       wgt_sel = w08;
            4'd8:       wgt_sel = w09;
            default:    wgt_sel = '0;
        endcase
    end

    // Greedy decision for the current bit and the residue that results from it.
    always_comb begin
        wgt_ext     = {{(RES_W-WGT_W){1'b0}}, wgt_sel};
        take        = en_out[idx] && (residue >= wgt_ext);
        residue_nxt = take ? (residue - wgt_ext) : residue;
    end

    // Control FSM: accept a word, step through bits 8..0, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            residue  <= '0;
            idx      <= 4'd8;
            code_out <= '0;
            en_out   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        residue  <= {{(RES_W-DATA_W){1'b0}}, data_in};
                        en_out   <= en_flag;
                        code_out <= '0;
                        err      <= 1'b0;
                        idx      <= 4'd8;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (take) begin
                        code_out[idx] <= 1'b1;
                    end
                    residue <= residue_nxt;
                    if (idx == 4'd0) begin
                        err   <= (residue_nxt != '0);
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_fns_enc_seq.sv
// Bench for fns_enc_seq: directed words with literal expectations plus a
// per-cycle comparison against a plain-arithmetic greedy FNS model.
module tb_fns_enc_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] data_in;
    logic [8:0] en_flag;
    logic [5:0] wv [2:8];
    logic       out_valid;
    logic       out_ready;
    logic [8:0] code_out;
    logic [8:0] en_out;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model state: is a word outstanding, edges since its accept, its expected result.
    bit         m_pending = 1'b0;
    int         m_since = 0;
    int         m_data = 0;
    logic [8:0] m_en = '0;
    logic [8:0] m_code = '0;
    logic       m_err = 1'b0;

    always #5 clk = ~clk;

    fns_enc_seq #(.DATA_W(7), .WGT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .en_flag(en_flag),
        .w03(wv[2]), .w04(wv[3]), .w05(wv[4]), .w06(wv[5]),
        .w07(wv[6]), .w08(wv[7]), .w09(wv[8]),
        .out_valid(out_valid), .out_ready(out_ready),
        .code_out(code_out), .en_out(en_out), .err(err)
    );

    function automatic int wt(input int k);
        if (k < 2) return 1;
        return int'(wv[k]);
    endfunction

    // Greedy representation: largest enabled weights first, leftover means not representable.
    function automatic void fns_model(input int value, input logic [8:0] en,
                                      output logic [8:0] code, output logic e);
        int rem;
        rem  = value;
        code = '0;
        for (int k = 8; k >= 0; k--) begin
            if (en[k] && rem >= wt(k)) begin
                code[k] = 1'b1;
                rem     = rem - wt(k);
            end
        end
        e = (rem != 0);
    endfunction

    function automatic int fns_decode(input logic [8:0] code);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) if (code[k]) s = s + wt(k);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timing and result, advanced on the same edges as the DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pending = 1'b0;
        end else if (m_pending) begin
            if (m_since >= 9 && out_ready) m_pending = 1'b0;
            else if (m_since < 9) m_since++;
        end else if (in_valid) begin
            m_pending = 1'b1;
            m_since   = 0;
            m_data    = int'(data_in);
            m_en      = en_flag;
            fns_model(m_data, m_en, m_code, m_err);
        end
    end

    // Every cycle: handshake outputs against the model; result fields whenever out_valid is due.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!m_pending));
            check("out_valid", 32'(out_valid), 32'(m_pending && m_since >= 9));
            if (m_pending && m_since >= 9) begin
                check("code_out", 32'(code_out), 32'(m_code));
                check("en_out", 32'(en_out), 32'(m_en));
                check("err", 32'(err), 32'(m_err));
                if (!m_err) check("decode", 32'(fns_decode(code_out)), 32'(m_data));
            end
        end
    end

    // Send one word, confirm latency and literal result, hold DONE for 'hold' cycles, release.
    task automatic run_word(input int data, input logic [8:0] en,
                            input logic [8:0] exp_code, input logic exp_err,
                            input int hold, input bit pulse);
        int edges;
        logic [8:0] c0;
        logic e0;
        @(negedge clk);
        data_in  = 7'(data);
        en_flag  = en;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
            if (pulse && edges == 4) begin
                in_valid = 1'b1;
                data_in  = 7'd3;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(edges), 32'd10);
        check("lit_code", 32'(code_out), 32'(exp_code));
        check("lit_err", 32'(err), 32'(exp_err));
        check("lit_en", 32'(en_out), 32'(en));
        c0 = code_out;
        e0 = err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == hold / 2) in_valid = 1'b1;
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_code", 32'(code_out), 32'(c0));
            check("hold_err", 32'(err), 32'(e0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        en_flag   = 9'h1FF;
        wv[2] = 6'd2;  wv[3] = 6'd3;  wv[4] = 6'd5;  wv[5] = 6'd8;
        wv[6] = 6'd13; wv[7] = 6'd21; wv[8] = 6'd34;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_code", 32'(code_out), 32'd0);
        check("rst_en", 32'(en_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        chk_en = 1'b1;

        run_word(0,   9'h1FF, 9'h000, 1'b0, 0,  1'b0);
        run_word(20,  9'h1FF, 9'h054, 1'b0, 0,  1'b0);
        run_word(88,  9'h1FF, 9'h1FF, 1'b0, 0,  1'b0);
        run_word(20,  9'h1BF, 9'h03F, 1'b0, 0,  1'b0);
        run_word(5,   9'h000, 9'h000, 1'b1, 0,  1'b0);
        run_word(100, 9'h1FF, 9'h1FF, 1'b1, 0,  1'b0);
        run_word(33,  9'h1FF, 9'h0AA, 1'b0, 20, 1'b1);
        run_word(1,   9'h1FF, 9'h002, 1'b0, 0,  1'b0);
        run_word(89,  9'h1FF, 9'h1FF, 1'b1, 0,  1'b0);

        // Reset while the encoder is at bit 4 of a word.
        @(negedge clk);
        data_in  = 7'd88;
        en_flag  = 9'h1FF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_code", 32'(code_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_en", 32'(en_out), 32'd0);
        run_word(20, 9'h1FF, 9'h054, 1'b0, 0, 1'b0);

        // Non-Fibonacci weights at the top of the weight range and the data range.
        @(negedge clk);
        for (int k = 2; k <= 8; k++) wv[k] = 6'd63;
        run_word(127, 9'h1FF, 9'h182, 1'b0, 3, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
